// File: rtl/aha_parallel_to_ahb_if.sv
`default_nettype none
// ============================================================================
//  Module      : aha_parallel_to_ahb_if
//  Description : Bundle of the PAR_* register-access handshake and the
//                AHB-Lite initiator signals used by aha_parallel_to_ahb.
//                The master modport is the bridge's view; the slave modport
//                is the view of the surrounding requester plus AHB fabric.
//  Revision    : 1.0  initial release
// ============================================================================
interface aha_parallel_to_ahb_if #(
  parameter int ADDR_WIDTH = 12
);
  // Parallel requester side
  logic [ADDR_WIDTH-1:0] PAR_ADDR;
  logic                  PAR_RD_EN;
  logic                  PAR_WR_EN;
  logic [3:0]            PAR_WR_STRB;
  logic [31:0]           PAR_WR_DATA;
  logic [31:0]           PAR_RD_DATA;
  logic                  PAR_ACK;
  logic                  PAR_NACK;
  logic                  PAR_BUSY;

  // AHB-Lite initiator side
  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic                  HMASTLOCK;
  logic [31:0]           HWDATA;
  logic [31:0]           HRDATA;
  logic                  HREADY;
  logic [1:0]            HRESP;

  modport master (
    input  PAR_ADDR, PAR_RD_EN, PAR_WR_EN, PAR_WR_STRB, PAR_WR_DATA,
    input  HRDATA, HREADY, HRESP,
    output PAR_RD_DATA, PAR_ACK, PAR_NACK, PAR_BUSY,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
  );

  modport slave (
    output PAR_ADDR, PAR_RD_EN, PAR_WR_EN, PAR_WR_STRB, PAR_WR_DATA,
    output HRDATA, HREADY, HRESP,
    input  PAR_RD_DATA, PAR_ACK, PAR_NACK, PAR_BUSY,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
  );
endinterface
`default_nettype wire

// File: rtl/aha_parallel_to_ahb.sv
`default_nettype none
// ============================================================================
//  Module      : aha_parallel_to_ahb
//  Description : AHB-Lite initiator that turns single PAR_* read/write
//                requests into single AHB transfers, one outstanding at a
//                time. Optional HREADY-low timeout is enabled by defining
//                the macro AHA_P2AHB_TIMEOUT_EN (adds port TIMEOUT_FLAG).
//  Revision    : 1.0  initial release
// ============================================================================
module aha_parallel_to_ahb #(
  parameter int          ADDR_WIDTH     = 12,
  parameter logic [31:0] BASE_ADDR      = 32'h4000_0000,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  aha_parallel_to_ahb_if.master bus
`ifdef AHA_P2AHB_TIMEOUT_EN
  ,
  output logic                  TIMEOUT_FLAG
`endif
);

  // FSM encoding
  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_ADDR = 2'd1;
  localparam logic [1:0] c_ST_DATA = 2'd2;
  localparam logic [1:0] c_ST_ERR  = 2'd3;

  // AHB encodings
  localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] c_HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] c_HSIZE_HALF    = 3'b001;
  localparam logic [2:0] c_HSIZE_WORD    = 3'b010;

  // Registered state and outputs
  logic [1:0]  state_q,   state_d;
  logic [31:0] haddr_q,   haddr_d;
  logic [1:0]  htrans_q,  htrans_d;
  logic        hwrite_q,  hwrite_d;
  logic [2:0]  hsize_q,   hsize_d;
  logic [31:0] hwdata_q,  hwdata_d;
  logic [31:0] wdata_q,   wdata_d;
  logic [31:0] rdata_q,   rdata_d;
  logic        ack_q,     ack_d;
  logic        nack_q,    nack_d;
  logic        busy_q,    busy_d;

  // Request decode
  logic        req_w;
  logic        accept_w;
  logic        dec_legal_w;
  logic [2:0]  dec_size_w;
  logic [1:0]  dec_off_w;

`ifdef AHA_P2AHB_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic               tflag_q, tflag_d;
`endif

  // Address bits [1:0] come from the strobe decode and HRESP[1] carries no
  // extra information for a single-transfer initiator.
  logic unused_w;
`ifdef AHA_P2AHB_TIMEOUT_EN
  assign unused_w = ^{bus.PAR_ADDR[1:0], bus.HRESP[1]};
`else
  assign unused_w = ^{bus.PAR_ADDR[1:0], bus.HRESP[1], (TIMEOUT_CYCLES > 0)};
`endif

  // A new request is only looked at once the previous one has fully retired
  assign req_w    = bus.PAR_RD_EN | bus.PAR_WR_EN;
  assign accept_w = (state_q == c_ST_IDLE) && !busy_q && req_w;

  // Strobe pattern -> transfer size and byte offset; anything else is refused
  always_comb begin
    dec_legal_w = 1'b1;
    dec_size_w  = c_HSIZE_WORD;
    dec_off_w   = 2'd0;
    if (bus.PAR_RD_EN && bus.PAR_WR_EN) begin
      dec_legal_w = 1'b0;
    end else if (bus.PAR_WR_EN) begin
      case (bus.PAR_WR_STRB)
        4'b1111: begin dec_size_w = c_HSIZE_WORD; dec_off_w = 2'd0; end
        4'b0011: begin dec_size_w = c_HSIZE_HALF; dec_off_w = 2'd0; end
        4'b1100: begin dec_size_w = c_HSIZE_HALF; dec_off_w = 2'd2; end
        4'b0001: begin dec_size_w = c_HSIZE_BYTE; dec_off_w = 2'd0; end
        4'b0010: begin dec_size_w = c_HSIZE_BYTE; dec_off_w = 2'd1; end
        4'b0100: begin dec_size_w = c_HSIZE_BYTE; dec_off_w = 2'd2; end
        4'b1000: begin dec_size_w = c_HSIZE_BYTE; dec_off_w = 2'd3; end
        default: dec_legal_w = 1'b0;
      endcase
    end
  end

  // Transfer sequencing: address phase, data phase, two-cycle error wait
  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    htrans_d = htrans_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    hwdata_d = hwdata_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ack_d    = 1'b0;
    nack_d   = 1'b0;
    busy_d   = busy_q;
`ifdef AHA_P2AHB_TIMEOUT_EN
    cnt_d    = cnt_q;
    tflag_d  = tflag_q;
`endif

    // BUSY drops in the cycle after the ACK/NACK pulse
    if (ack_q || nack_q) begin
      busy_d = 1'b0;
    end

    case (state_q)
      c_ST_IDLE: begin
        if (accept_w) begin
          busy_d = 1'b1;
          if (dec_legal_w) begin
            state_d  = c_ST_ADDR;
            htrans_d = c_HTRANS_NONSEQ;
            haddr_d  = {BASE_ADDR[31:ADDR_WIDTH],
                        bus.PAR_ADDR[ADDR_WIDTH-1:2], dec_off_w};
            hwrite_d = bus.PAR_WR_EN;
            hsize_d  = dec_size_w;
            wdata_d  = bus.PAR_WR_DATA;
          end else begin
            nack_d = 1'b1;
          end
        end
      end

      c_ST_ADDR: begin
        // Address/control stay frozen until the slave accepts them
        if (bus.HREADY) begin
          state_d  = c_ST_DATA;
          htrans_d = c_HTRANS_IDLE;
          if (hwrite_q) begin
            hwdata_d = wdata_q;
          end
        end
      end

      c_ST_DATA: begin
        if (bus.HRESP[0]) begin
          if (bus.HREADY) begin
            // Single-cycle ERROR is a slave protocol violation; still fail it
            nack_d  = 1'b1;
            state_d = c_ST_IDLE;
          end else begin
            state_d = c_ST_ERR;
          end
        end else if (bus.HREADY) begin
          ack_d   = 1'b1;
          state_d = c_ST_IDLE;
          if (!hwrite_q) begin
            rdata_d = bus.HRDATA;
          end
        end
      end

      c_ST_ERR: begin
        if (bus.HREADY) begin
          nack_d  = 1'b1;
          state_d = c_ST_IDLE;
        end
      end

      default: begin
        state_d  = c_ST_IDLE;
        htrans_d = c_HTRANS_IDLE;
      end
    endcase

`ifdef AHA_P2AHB_TIMEOUT_EN
    // Abandon a transfer after too many consecutive HREADY-low cycles
    if (state_q == c_ST_IDLE || bus.HREADY) begin
      cnt_d = '0;
    end else if (cnt_q == c_CNT_W'(TIMEOUT_CYCLES - 1)) begin
      cnt_d    = '0;
      state_d  = c_ST_IDLE;
      htrans_d = c_HTRANS_IDLE;
      ack_d    = 1'b0;
      nack_d   = 1'b1;
      tflag_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + c_CNT_W'(1);
    end
`endif
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= c_ST_IDLE;
      haddr_q  <= '0;
      htrans_q <= c_HTRANS_IDLE;
      hwrite_q <= 1'b0;
      hsize_q  <= c_HSIZE_WORD;
      hwdata_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      nack_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
      hwdata_q <= hwdata_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      nack_q   <= nack_d;
      busy_q   <= busy_d;
    end
  end

`ifdef AHA_P2AHB_TIMEOUT_EN
  // Timeout counter and sticky flag
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      tflag_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tflag_q <= tflag_d;
    end
  end

  assign TIMEOUT_FLAG = tflag_q;
`endif

  assign bus.PAR_RD_DATA = rdata_q;
  assign bus.PAR_ACK     = ack_q;
  assign bus.PAR_NACK    = nack_q;
  assign bus.PAR_BUSY    = busy_q;
  assign bus.HADDR       = haddr_q;
  assign bus.HTRANS      = htrans_q;
  assign bus.HWRITE      = hwrite_q;
  assign bus.HSIZE       = hsize_q;
  assign bus.HBURST      = 3'b000;
  assign bus.HPROT       = 4'b0011;
  assign bus.HMASTLOCK   = 1'b0;
  assign bus.HWDATA      = hwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_aha_parallel_to_ahb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aha_parallel_to_ahb
//  Description : Self-checking bench for aha_parallel_to_ahb. Directed
//                scenarios plus randomized transfers against a behavioural
//                reference model; the bench acts as requester and AHB slave.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aha_parallel_to_ahb;

  localparam logic [31:0] c_BASE = 32'h4000_0000;

  logic clk;
  logic reset;
`ifdef AHA_P2AHB_TIMEOUT_EN
  logic tflag;
`endif

  aha_parallel_to_ahb_if #(.ADDR_WIDTH(12)) bus ();

  aha_parallel_to_ahb #(
    .ADDR_WIDTH     (12),
    .BASE_ADDR      (c_BASE),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus)
`ifdef AHA_P2AHB_TIMEOUT_EN
    ,
    .TIMEOUT_FLAG (tflag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model_rd;
  logic [31:0] model_hwdata;

  // One comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Move to 1 time unit after the next active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decode: what the request should become on the bus
  function automatic void ref_decode(input bit rd, input bit wr, input logic [3:0] strb,
                                     output bit legal, output int size, output int off);
    int ones;
    legal = 1'b0;
    size  = 2;
    off   = 0;
    ones  = $countones(strb);
    if (rd && wr) begin
      legal = 1'b0;
    end else if (rd) begin
      legal = 1'b1;
    end else if (strb == 4'hF) begin
      legal = 1'b1;
    end else if (strb == 4'h3 || strb == 4'hC) begin
      legal = 1'b1;
      size  = 1;
      off   = (strb == 4'hC) ? 2 : 0;
    end else if (ones == 1) begin
      legal = 1'b1;
      size  = 0;
      for (int b = 0; b < 4; b++) if (strb[b]) off = b;
    end
  endfunction

  // One complete request; the bench plays the AHB slave with 'waits' wait
  // states and err = 0 (OKAY), 1 (two-cycle ERROR), 2 (single-cycle ERROR)
  task automatic do_xfer(input bit rd, input bit wr, input logic [11:0] addr,
                         input logic [3:0] strb, input logic [31:0] wdata,
                         input int waits, input int err, input logic [31:0] rdata);
    bit          legal;
    int          size;
    int          off;
    logic [31:0] exp_addr;
    ref_decode(rd, wr, strb, legal, size, off);
    exp_addr = (c_BASE & 32'hFFFF_F000) + {20'h0, addr & 12'hFFC} + 32'(off);

    bus.HREADY      = 1'b1;
    bus.HRESP       = 2'b00;
    bus.PAR_ADDR    = addr;
    bus.PAR_RD_EN   = rd;
    bus.PAR_WR_EN   = wr;
    bus.PAR_WR_STRB = strb;
    bus.PAR_WR_DATA = wdata;
    tick();
    bus.PAR_RD_EN   = 1'b0;
    bus.PAR_WR_EN   = 1'b0;
    bus.PAR_WR_DATA = $urandom;
    bus.PAR_WR_STRB = 4'($urandom);

    if (!legal) begin
      chk("illegal_nack",   bus.PAR_NACK, 1);
      chk("illegal_ack",    bus.PAR_ACK,  0);
      chk("illegal_htrans", bus.HTRANS,   0);
      chk("illegal_busy",   bus.PAR_BUSY, 1);
      tick();
      chk("illegal_nack_end", bus.PAR_NACK, 0);
      chk("illegal_busy_end", bus.PAR_BUSY, 0);
      chk("illegal_htrans2",  bus.HTRANS,   0);
      return;
    end

    // Address phase
    chk("addr_htrans", bus.HTRANS, 2);
    chk("addr_haddr",  bus.HADDR,  exp_addr);
    chk("addr_hsize",  bus.HSIZE,  32'(size));
    chk("addr_hwrite", bus.HWRITE, 32'(wr));
    chk("addr_hwdata_hold", bus.HWDATA, model_hwdata);
    chk("addr_resp", {bus.PAR_ACK, bus.PAR_NACK}, 0);
    tick();

    // Data phase
    if (wr) model_hwdata = wdata;
    chk("data_htrans", bus.HTRANS, 0);
    chk("data_hwdata", bus.HWDATA, model_hwdata);
    for (int w = 0; w < waits; w++) begin
      bus.HREADY = 1'b0;
      bus.HRESP  = 2'b00;
      bus.HRDATA = $urandom;
      tick();
      chk("wait_resp",   {bus.PAR_ACK, bus.PAR_NACK}, 0);
      chk("wait_htrans", bus.HTRANS, 0);
    end
    case (err)
      1: begin
        bus.HREADY = 1'b0;
        bus.HRESP  = 2'b01;
        bus.HRDATA = $urandom;
        tick();
        chk("err1_resp", {bus.PAR_ACK, bus.PAR_NACK}, 0);
        bus.HREADY = 1'b1;
        tick();
      end
      2: begin
        bus.HREADY = 1'b1;
        bus.HRESP  = 2'b01;
        bus.HRDATA = $urandom;
        tick();
      end
      default: begin
        bus.HREADY = 1'b1;
        bus.HRESP  = 2'b00;
        bus.HRDATA = rdata;
        tick();
      end
    endcase

    // Response cycle
    if (err == 0 && rd) model_rd = rdata;
    chk("resp_ack",    bus.PAR_ACK,     32'(err == 0));
    chk("resp_nack",   bus.PAR_NACK,    32'(err != 0));
    chk("resp_rdata",  bus.PAR_RD_DATA, model_rd);
    chk("resp_busy",   bus.PAR_BUSY,    1);
    bus.HREADY = 1'b1;
    bus.HRESP  = 2'b00;
    bus.HRDATA = $urandom;
    tick();
    chk("post_resp", {bus.PAR_ACK, bus.PAR_NACK}, 0);
    chk("post_busy", bus.PAR_BUSY, 0);
    chk("post_htrans", bus.HTRANS, 0);
  endtask

  initial begin
    int          nonseq;
    int          acks;
    int          r;
    bit          rd;
    bit          wr;
    logic [3:0]  strb;
    logic [3:0]  legal_strb [8];

    legal_strb = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'hF};
    model_rd     = '0;
    model_hwdata = '0;

    // Reset
    reset           = 1'b1;
    bus.PAR_ADDR    = '0;
    bus.PAR_RD_EN   = 1'b0;
    bus.PAR_WR_EN   = 1'b0;
    bus.PAR_WR_STRB = '0;
    bus.PAR_WR_DATA = '0;
    bus.HRDATA      = '0;
    bus.HREADY      = 1'b1;
    bus.HRESP       = 2'b00;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_htrans",  bus.HTRANS,      0);
    chk("rst_hsize",   bus.HSIZE,       2);
    chk("rst_haddr",   bus.HADDR,       0);
    chk("rst_hwrite",  bus.HWRITE,      0);
    chk("rst_hwdata",  bus.HWDATA,      0);
    chk("rst_rdata",   bus.PAR_RD_DATA, 0);
    chk("rst_acknack", {bus.PAR_ACK, bus.PAR_NACK, bus.PAR_BUSY}, 0);
    chk("rst_hburst",  bus.HBURST,      0);
    chk("rst_hprot",   bus.HPROT,       4'b0011);
    chk("rst_hlock",   bus.HMASTLOCK,   0);
`ifdef AHA_P2AHB_TIMEOUT_EN
    chk("rst_tflag",   tflag,           0);
`endif

    // Zero-wait read
    do_xfer(1'b1, 1'b0, 12'h010, 4'h0, 32'h0, 0, 0, 32'hDEAD_BEEF);
    chk("tp_read_haddr", bus.HADDR,       32'h4000_0010);
    chk("tp_read_rdata", bus.PAR_RD_DATA, 32'hDEAD_BEEF);

    // Byte write, two wait states
    do_xfer(1'b0, 1'b1, 12'h020, 4'b0100, 32'h00AB_0000, 2, 0, 32'h0);
    chk("tp_bw_haddr",  bus.HADDR,  32'h4000_0022);
    chk("tp_bw_hsize",  bus.HSIZE,  0);
    chk("tp_bw_hwdata", bus.HWDATA, 32'h00AB_0000);

    // Two-cycle error on a read: read data must not move
    do_xfer(1'b1, 1'b0, 12'h044, 4'h0, 32'h0, 1, 1, 32'h5555_AAAA);
    chk("tp_err_rdata", bus.PAR_RD_DATA, 32'hDEAD_BEEF);
    // Single-cycle error on a write
    do_xfer(1'b0, 1'b1, 12'h048, 4'hF, 32'hCAFE_F00D, 0, 2, 32'h0);

    // Illegal requests
    do_xfer(1'b0, 1'b1, 12'h050, 4'b0101, 32'h1111_2222, 0, 0, 32'h0);
    do_xfer(1'b0, 1'b1, 12'h050, 4'b0000, 32'h3333_4444, 0, 0, 32'h0);
    do_xfer(1'b1, 1'b1, 12'h054, 4'hF,    32'h5555_6666, 0, 0, 32'h0);

    // Pulses while busy are ignored
    bus.HREADY    = 1'b1;
    bus.HRESP     = 2'b00;
    bus.HRDATA    = 32'h1234_5678;
    bus.PAR_ADDR  = 12'h100;
    bus.PAR_RD_EN = 1'b1;
    tick();
    nonseq = 0;
    acks   = 0;
    for (int c = 1; c <= 8; c++) begin
      bus.PAR_RD_EN = (c == 1 || c == 3);
      if (bus.HTRANS == 2'b10) nonseq++;
      if (bus.PAR_ACK) acks++;
      tick();
    end
    bus.PAR_RD_EN = 1'b0;
    model_rd = 32'h1234_5678;
    chk("busy_nonseq_count", 32'(nonseq), 1);
    chk("busy_ack_count",    32'(acks),   1);
    chk("busy_rdata",        bus.PAR_RD_DATA, model_rd);

    // Reset in the data phase
    bus.PAR_RD_EN = 1'b1;
    bus.PAR_ADDR  = 12'h200;
    tick();
    bus.PAR_RD_EN = 1'b0;
    tick();
    bus.HREADY = 1'b0;
    reset      = 1'b1;
    tick();
    chk("rstmid_htrans", bus.HTRANS,   0);
    chk("rstmid_busy",   bus.PAR_BUSY, 0);
    chk("rstmid_resp",   {bus.PAR_ACK, bus.PAR_NACK}, 0);
    chk("rstmid_rdata",  bus.PAR_RD_DATA, 0);
    reset      = 1'b0;
    bus.HREADY = 1'b1;
    model_rd     = '0;
    model_hwdata = '0;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.PAR_ACK || bus.PAR_NACK || bus.HTRANS != 2'b00) acks++;
      tick();
    end
    chk("rstmid_quiet", 32'(acks), 0);

`ifdef AHA_P2AHB_TIMEOUT_EN
    // Timeout after 8 HREADY-low cycles
    bus.PAR_RD_EN = 1'b1;
    bus.PAR_ADDR  = 12'h300;
    tick();
    bus.PAR_RD_EN = 1'b0;
    bus.HREADY    = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk("to_early_nack", bus.PAR_NACK, 0);
      chk("to_early_flag", tflag,        0);
      tick();
    end
    chk("to_nack",   bus.PAR_NACK, 1);
    chk("to_ack",    bus.PAR_ACK,  0);
    chk("to_flag",   tflag,        1);
    chk("to_htrans", bus.HTRANS,   0);
    bus.HREADY = 1'b1;
    tick();
    chk("to_busy_end", bus.PAR_BUSY, 0);
    do_xfer(1'b1, 1'b0, 12'h304, 4'h0, 32'h0, 1, 0, 32'h0BAD_F00D);
    chk("to_flag_sticky", tflag, 1);
`endif

    // Randomized requests
    for (int i = 0; i < 40; i++) begin
      r  = int'($urandom_range(0, 9));
      rd = (r < 4) || (r == 9);
      wr = (r >= 4);
      strb = ($urandom_range(0, 1) == 0) ? legal_strb[$urandom_range(0, 7)] : 4'($urandom);
      do_xfer(rd, wr, 12'($urandom), strb, $urandom,
              int'($urandom_range(0, 3)),
              ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0,
              $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aha_parallel_to_ahb.md
Name: aha_parallel_to_ahb

Overview:
- AHB-Lite initiator that converts the team's simple parallel register-access interface (PAR_* request/ack/nack) into single AHB transfers.
- It is the initiator-side counterpart of the AHB-to-parallel responder that fronts the platform-controller register space.
- Lets an internal sequencer or debug/config engine access any AHB register space through the same PAR_* handshake.
- Sits between a parallel requester and an AHB slave port or interconnect, one outstanding transfer at a time.

Parameters:
- ADDR_WIDTH, 12, width of PAR_ADDR (byte address; bits [1:0] ignored).
- BASE_ADDR, 32'h4000_0000, supplies HADDR[31:ADDR_WIDTH].
- TIMEOUT_CYCLES, 256, HREADY-low cycle limit; only used when AHA_P2AHB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- PAR_ADDR  in  ADDR_WIDTH  byte address of request.
- PAR_RD_EN  in  1  one-cycle read request pulse.
- PAR_WR_EN  in  1  one-cycle write request pulse.
- PAR_WR_STRB  in  4  write byte strobes.
- PAR_WR_DATA  in  32  write data, lane-aligned.
- PAR_RD_DATA  out  32  read data; valid with PAR_ACK, held until next read ACK.
- PAR_ACK  out  1  one-cycle success pulse.
- PAR_NACK  out  1  one-cycle failure pulse.
- PAR_BUSY  out  1  high from accept until the cycle after ACK/NACK.
- HADDR  out  32  AHB address.
- HTRANS  out  2  AHB transfer type; only IDLE or NONSEQ is driven.
- HWRITE  out  1  AHB direction.
- HSIZE  out  3  AHB transfer size.
- HBURST  out  3  constant 3'b000 (SINGLE).
- HPROT  out  4  constant 4'b0011.
- HMASTLOCK  out  1  constant 0.
- HWDATA  out  32  AHB write data.
- HRDATA  in  32  AHB read data.
- HREADY  in  1  AHB ready.
- HRESP  in  2  AHB response; bit0 = ERROR.

Behaviour:
- Reset values: all registered outputs are 0, except HSIZE=3'b010. The FSM goes to IDLE. Reset mid-transfer drives HTRANS=IDLE in the following cycle and issues no ACK/NACK.
- Request acceptance:
  - Requests are sampled only in IDLE; pulses arriving while PAR_BUSY=1 are ignored.
  - PAR_RD_EN and PAR_WR_EN both high: PAR_NACK in the next cycle, no bus transfer.
- Size/offset decode:
  - Read: HSIZE=word, offset 0, strobes ignored.
  - Write strobe 1111: word, offset 0.
  - Write strobe 0011 / 1100: halfword, offset 0 / 2.
  - Write with a single strobe bit n: byte, offset n.
  - Write strobe 0000 or any other pattern: PAR_NACK next cycle, no bus transfer.
- Address: HADDR = {BASE_ADDR[31:ADDR_WIDTH], PAR_ADDR[ADDR_WIDTH-1:2], offset}. Address and write data are captured at acceptance.
- FSM states:
  - IDLE: on a valid request go to ADDR; HTRANS=NONSEQ plus address/control are registered.
  - ADDR: hold NONSEQ and all controls stable while HREADY=0. At the edge with HREADY=1, go to DATA; HTRANS becomes IDLE and HWDATA carries the captured data.
  - DATA, HREADY=1 and HRESP[0]=0: capture HRDATA (reads), pulse PAR_ACK next cycle, go to IDLE.
  - DATA, HRESP[0]=1 and HREADY=0 (first error cycle): go to ERR.
  - DATA, HREADY=1 and HRESP[0]=1 (protocol-violating single-cycle error): treated as error, PAR_NACK pulse.
  - ERR: wait for HREADY=1, then pulse PAR_NACK and go to IDLE. PAR_RD_DATA is unchanged.
- Latency, zero-wait-state slave: request at cycle 0, NONSEQ in cycle 1, data phase in cycle 2, PAR_ACK in cycle 3. Each slave wait state adds 1 cycle.
- PAR_ACK and PAR_NACK are never high together. Each accepted request produces exactly one of them.
- HWDATA holds its last value outside the data phase.

Optional Feature:
- Macro: AHA_P2AHB_TIMEOUT_EN.
- Defined:
  - A counter runs in ADDR/DATA/ERR and resets on every HREADY=1 cycle.
  - When it reaches TIMEOUT_CYCLES consecutive HREADY-low cycles, the block pulses PAR_NACK, drives HTRANS=IDLE and returns to IDLE.
  - Sticky output TIMEOUT_FLAG (out, 1) is set at the same time and cleared only by reset.
- Undefined: no counter and no TIMEOUT_FLAG port; the block waits on HREADY indefinitely.

Test Plan:
- Read with zero-wait slave: PAR_ADDR=12'h010, RD_EN pulse at cycle 0 → HADDR=32'h4000_0010, HSIZE=2, HWRITE=0, NONSEQ in cycle 1; HRDATA=32'hDEAD_BEEF in cycle 2 → PAR_ACK and PAR_RD_DATA=32'hDEAD_BEEF in cycle 3.
- Byte write with 2 wait states: STRB=4'b0100, ADDR=12'h020, data 32'h00AB_0000 → HADDR=32'h4000_0022, HSIZE=0, HWDATA=32'h00AB_0000; PAR_ACK 5 cycles after request.
- Error response: slave gives HRESP=ERROR with HREADY=0, then HRESP=ERROR with HREADY=1 → single PAR_NACK, no PAR_ACK, PAR_RD_DATA unchanged.
- Illegal requests: STRB=4'b0101 write, and RD_EN+WR_EN together → PAR_NACK next cycle, HTRANS stays IDLE throughout.
- Busy/reset: a second RD_EN while PAR_BUSY=1 is ignored (one HTRANS=NONSEQ only). Reset asserted in DATA → HTRANS=IDLE, PAR_BUSY=0 next cycle, no ACK/NACK.
- With AHA_P2AHB_TIMEOUT_EN and TIMEOUT_CYCLES=8: HREADY held 0 → PAR_NACK and TIMEOUT_FLAG=1 after 8 low cycles; FSM back in IDLE.
